// File: rtl/scu_pkg.sv
// Shared definitions for the simple-control-unit program sequencer:
// opcode constants, opcode field position and the sequencer state type.
package scu_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_IMM,
        ST_WAIT,
        ST_HALT
    } seq_state_t;

    // Extract the opcode field from the low nine bits of an instruction word.
    function automatic logic [2:0] get_opcode(input logic [8:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/scu_prog_ram.sv
// Program store: one write port, one synchronous read port, no reset on
// the array. A read and a write to the same address in the same cycle
// return the new word, so a program loaded together with start is seen.
module scu_prog_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Commit program writes.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read with write-first forwarding on an address collision.
    always_ff @(posedge clk) begin
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/scu_program_sequencer.sv
// Instruction issuer for the simple control unit's Din/Run/Done handshake.
// Fetches words from a local program store, pulses Run with each word,
// follows mvi with its immediate word and waits for Done between issues.
// The store read address is driven one cycle ahead of the state that uses
// the data, which is what lets Run appear two cycles after start or Done.
// Optional build macro: SCU_SEQ_TIMEOUT_EN enables the Done watchdog and
// the sticky error flag; without it error is tied low.
module scu_program_sequencer
    import scu_pkg::*;
#(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_wdata,
    input  logic              start,
    output logic [DATA_W-1:0] Din,
    output logic              Run,
    input  logic              Done,
    output logic              busy,
    output logic              halted,
    output logic              error,
    output logic [ADDR_W-1:0] pc
);

    seq_state_t        state;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              ram_we;
    logic              idle_or_halt;
    logic              start_ok;
    logic              cur_mvi;
    logic              halt_pending;
    logic              timeout_hit;
    logic [ADDR_W:0]   adv_sum;
    logic [2:0]        fetched_op;

    assign idle_or_halt = (state == ST_IDLE) || (state == ST_HALT);
    assign ram_we       = prog_we && idle_or_halt;
    assign start_ok     = start && idle_or_halt;
    assign adv_sum      = {1'b0, pc} + {{(ADDR_W-1){1'b0}}, cur_mvi, ~cur_mvi};
    assign fetched_op   = get_opcode(rd_data[8:0]);

    scu_prog_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Read address for the word the next state will consume.
    always_comb begin
        rd_addr = pc;
        case (state)
            ST_IDLE, ST_HALT: if (start) rd_addr = '0;
            ST_FETCH:         rd_addr = pc + ADDR_W'(1);
            ST_WAIT, ST_IMM:  if (Done) rd_addr = adv_sum[ADDR_W-1:0];
            default:          rd_addr = pc;
        endcase
    end

`ifdef SCU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             error_q;

    assign timeout_hit = ((state == ST_WAIT) || (state == ST_IMM)) && !Done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign error = error_q;

    // Watchdog: count WAIT/IMM cycles per instruction, flag an expiry until restart.
    always_ff @(posedge clk) begin
        if (Reset) begin
            wait_cnt <= '0;
            error_q  <= 1'b0;
        end else begin
            if (state == ST_FETCH) begin
                wait_cnt <= '0;
            end else if ((state == ST_WAIT) || (state == ST_IMM)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (start_ok) begin
                error_q <= 1'b0;
            end else if (timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES[0];
    assign timeout_hit    = 1'b0;
    assign error          = 1'b0;
`endif

    // Sequencer FSM with registered Din, Run, pc, busy and halted.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= ST_IDLE;
            Din          <= '0;
            Run          <= 1'b0;
            pc           <= '0;
            busy         <= 1'b0;
            halted       <= 1'b0;
            cur_mvi      <= 1'b0;
            halt_pending <= 1'b0;
        end else begin
            Run <= 1'b0;
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        pc     <= '0;
                        state  <= ST_FETCH;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state        <= ST_ISSUE;
                    halt_pending <= (fetched_op == OP_HALT);
                    cur_mvi      <= (fetched_op == OP_MVI);
                    if (fetched_op != OP_HALT) begin
                        Din <= rd_data;
                        Run <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (halt_pending) begin
                        state  <= ST_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (cur_mvi) begin
                        Din   <= rd_data;
                        state <= ST_IMM;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_IMM, ST_WAIT: begin
                    if (Done) begin
                        pc <= adv_sum[ADDR_W-1:0];
                        if (adv_sum[ADDR_W]) begin
                            state  <= ST_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end else if (timeout_hit) begin
                        state  <= ST_HALT;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
